// File: rtl/image_mem_pkg.sv
// rtl/image_mem_pkg.sv - shared state codes, header format and word geometry for image_mem_reader
package image_mem_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_REQ        = 3'd1;
    localparam state_t ST_WAIT_SPACE = 3'd2;
    localparam state_t ST_DRAIN      = 3'd3;
    localparam state_t ST_HDR        = 3'd4;

    localparam logic [31:0] HDR_MAGIC      = 32'hFACE_0000;
    localparam int unsigned BYTES_PER_WORD = 16;

    function automatic logic [127:0] make_header(input logic [1:0] cam, input logic [23:0] bursts);
        return {HDR_MAGIC | {30'd0, cam}, 8'h00, bursts, 64'h0};
    endfunction

endpackage

// File: rtl/image_mem_reader_if.sv
// rtl/image_mem_reader_if.sv - control, MIG read port and pipe FIFO signals of image_mem_reader
interface image_mem_reader_if;

    logic         start;
    logic [29:0]  start_addr;
    logic [23:0]  frame_bursts;

    logic         mem_rd_req;
    logic [28:0]  mem_rd_addr;
    logic         mem_rd_ack;
    logic         mem_rdata_valid;
    logic [127:0] mem_rdata;

    logic [9:0]   pipe_wr_count;
    logic         pipe_full;
    logic         pipe_wr_en;
    logic [127:0] pipe_wr_data;

    logic         frame_read;
    logic [1:0]   cam_index;
    logic         all_done;
    logic         busy;
    logic         overflow;

    modport master (
        input  start, start_addr, frame_bursts,
        input  mem_rd_ack, mem_rdata_valid, mem_rdata,
        input  pipe_wr_count, pipe_full,
        output mem_rd_req, mem_rd_addr,
        output pipe_wr_en, pipe_wr_data,
        output frame_read, cam_index, all_done, busy, overflow
    );

    modport slave (
        output start, start_addr, frame_bursts,
        output mem_rd_ack, mem_rdata_valid, mem_rdata,
        output pipe_wr_count, pipe_full,
        input  mem_rd_req, mem_rd_addr,
        input  pipe_wr_en, pipe_wr_data,
        input  frame_read, cam_index, all_done, busy, overflow
    );

endinterface

// File: rtl/image_mem_reader.sv
// rtl/image_mem_reader.sv - credit-throttled DDR burst reader streaming camera frames to the pipe FIFO
// Optional per-frame header word: define IMGRD_FRAME_HEADER_EN.
module image_mem_reader
    import image_mem_pkg::*;
#(
    parameter int unsigned NUM_CAMERAS = 3,
    parameter int unsigned BURST_WORDS = 8,
    parameter int unsigned FIFO_DEPTH  = 512
) (
    input  logic               mem_clk,
    input  logic               mem_reset,
    image_mem_reader_if.master bus
);

    state_t        r_state;
    logic [29:0]   r_addr;
    logic [23:0]   r_frame_bursts;
    logic [23:0]   r_bursts_left;
    logic [1:0]    r_req_cam;
    logic [1:0]    r_rx_cam;
    logic [15:0]   r_outstanding;
    logic [31:0]   r_rx_words;
    logic          r_req;
    logic          r_wr_en;
    logic [127:0]  r_wr_data;
    logic          r_frame_read;
    logic [1:0]    r_cam_index;
    logic          r_all_done;
    logic          r_busy;
    logic          r_overflow;

    logic          w_ack;
    logic          w_beat;
    logic          w_credit_ok;
    logic          w_last_cam;
    logic          w_set_done;
    logic          w_rx_last;
    logic [31:0]   w_frame_words;
    logic [15:0]   w_outstanding_nxt;

    assign w_ack  = r_req & bus.mem_rd_ack;
    // Words returning with nothing outstanding belong to a set aborted by reset.
    assign w_beat = bus.mem_rdata_valid & (r_outstanding != 16'd0);

    assign w_frame_words     = 32'(r_frame_bursts) * 32'(BURST_WORDS);
    assign w_credit_ok       = (32'(bus.pipe_wr_count) + 32'(r_outstanding) + 32'(BURST_WORDS))
                               <= 32'(FIFO_DEPTH);
    assign w_last_cam        = (r_req_cam == 2'(NUM_CAMERAS - 1));
    assign w_set_done        = (r_rx_cam == 2'(NUM_CAMERAS));
    assign w_rx_last         = ((r_rx_words + 32'd1) == w_frame_words);
    assign w_outstanding_nxt = r_outstanding + (w_ack ? 16'(BURST_WORDS) : 16'd0)
                                             - (w_beat ? 16'd1 : 16'd0);

    always_ff @(posedge mem_clk or posedge mem_reset) begin
        if (mem_reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_frame_bursts <= '0;
            r_bursts_left  <= '0;
            r_req_cam      <= '0;
            r_rx_cam       <= '0;
            r_outstanding  <= '0;
            r_rx_words     <= '0;
            r_req          <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_data      <= '0;
            r_frame_read   <= 1'b0;
            r_cam_index    <= '0;
            r_all_done     <= 1'b0;
            r_busy         <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_wr_en       <= 1'b0;
            r_frame_read  <= 1'b0;
            r_all_done    <= 1'b0;
            r_outstanding <= w_outstanding_nxt;
            r_overflow    <= r_overflow | (r_wr_en & bus.pipe_full);

            if (w_beat) begin
                r_wr_en     <= 1'b1;
                r_wr_data   <= bus.mem_rdata;
                r_cam_index <= r_rx_cam;
                if (w_rx_last) begin
                    r_frame_read <= 1'b1;
                    r_rx_words   <= '0;
                    r_rx_cam     <= r_rx_cam + 2'd1;
                end else begin
                    r_rx_words <= r_rx_words + 32'd1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_addr         <= bus.start_addr;
                        r_frame_bursts <= bus.frame_bursts;
                        r_bursts_left  <= bus.frame_bursts;
                        r_req_cam      <= '0;
                        r_rx_cam       <= '0;
                        r_rx_words     <= '0;
                        r_busy         <= 1'b1;
                        if (bus.frame_bursts == 24'd0) begin
                            r_state <= ST_DRAIN;
                        end else begin
`ifdef IMGRD_FRAME_HEADER_EN
                            r_state <= ST_HDR;
`else
                            r_req   <= w_credit_ok;
                            r_state <= w_credit_ok ? ST_REQ : ST_WAIT_SPACE;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_req  <= 1'b0;
                        r_addr <= r_addr + 30'(BURST_WORDS * BYTES_PER_WORD);
                        if (r_bursts_left == 24'd1) begin
                            if (w_last_cam) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_req_cam     <= r_req_cam + 2'd1;
                                r_bursts_left <= r_frame_bursts;
`ifdef IMGRD_FRAME_HEADER_EN
                                r_state       <= ST_HDR;
`else
                                r_state       <= ST_WAIT_SPACE;
`endif
                            end
                        end else begin
                            r_bursts_left <= r_bursts_left - 24'd1;
                            r_state       <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (w_credit_ok) begin
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
`ifdef IMGRD_FRAME_HEADER_EN
                ST_HDR: begin
                    // Nothing outstanding, so the data register is free for the header.
                    if (r_outstanding == 16'd0 && 32'(bus.pipe_wr_count) < 32'(FIFO_DEPTH)) begin
                        r_wr_en     <= 1'b1;
                        r_wr_data   <= make_header(r_req_cam, r_frame_bursts);
                        r_cam_index <= r_req_cam;
                        r_state     <= ST_WAIT_SPACE;
                    end
                end
`endif
                ST_DRAIN: begin
                    if (w_set_done && r_outstanding == 16'd0) begin
                        r_all_done <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (r_frame_bursts == 24'd0 && !w_set_done) begin
                        r_frame_read <= 1'b1;
                        r_cam_index  <= r_rx_cam;
                        r_rx_cam     <= r_rx_cam + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_rd_req   = r_req;
    assign bus.mem_rd_addr  = r_addr[28:0];
    assign bus.pipe_wr_en   = r_wr_en;
    assign bus.pipe_wr_data = r_wr_data;
    assign bus.frame_read   = r_frame_read;
    assign bus.cam_index    = r_cam_index;
    assign bus.all_done     = r_all_done;
    assign bus.busy         = r_busy;
    assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_image_mem_reader.sv
// tb/tb_image_mem_reader.sv - directed bench with a frame-level model and a per-cycle output checker
module tb_image_mem_reader;

`ifdef IMGRD_FRAME_HEADER_EN
    localparam int HDRW = 1;
`else
    localparam int HDRW = 0;
`endif

    logic mem_clk = 1'b0;
    logic mem_reset = 1'b1;
    always #5 mem_clk = ~mem_clk;

    image_mem_reader_if bus();

    image_mem_reader #(.NUM_CAMERAS(3), .BURST_WORDS(8), .FIFO_DEPTH(512)) dut (
        .mem_clk   (mem_clk),
        .mem_reset (mem_reset),
        .bus       (bus)
    );

    typedef struct {
        logic [127:0] data;
        logic         fend;
        logic [1:0]   cam;
    } word_t;

    typedef struct {
        int           ready;
        logic [127:0] data;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    word_t       exp_words[$];
    logic [28:0] exp_addrs[$];
    beat_t       beat_q[$];
    int          fr_cyc_q[$];
    word_t       cmp_e;

    int ack_delay = 2;
    int data_delay = 10;
    int req_run = 0;
    int ack_cnt, wr_cnt, fr_cnt, done_cnt, req_cycles, done_cyc, overlap_cnt;
    logic zb_mode = 1'b0;
    logic [28:0] first_ack_addr, last_ack_addr;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_word(input logic [28:0] a);
        logic [31:0] x;
        x = {3'b000, a};
        return {x, ~x, 32'hC0DE_0000 ^ x, 32'h1234_5678 + x};
    endfunction

    // Expected request addresses and written words for one set, frame by frame.
    task automatic load_model(input logic [29:0] sa, input int fb);
        exp_words.delete();
        exp_addrs.delete();
        for (int cam = 0; cam < 3; cam++) begin
            if (HDRW == 1 && fb != 0) begin
                word_t h;
                h.data = {32'hFACE_0000 | 32'(cam), 8'h00, 24'(fb), 64'h0};
                h.fend = 1'b0;
                h.cam  = 2'(cam);
                exp_words.push_back(h);
            end
            for (int b = 0; b < fb; b++) begin
                logic [29:0] ba;
                ba = sa + 30'((cam * fb + b) * 128);
                exp_addrs.push_back(ba[28:0]);
                for (int w = 0; w < 8; w++) begin
                    word_t x;
                    x.data = mem_word(ba[28:0] + 29'(w * 16));
                    x.fend = (b == fb - 1) && (w == 7);
                    x.cam  = 2'(cam);
                    exp_words.push_back(x);
                end
            end
        end
    endtask

    // Arbiter / MIG responder: ack after ack_delay request cycles, data data_delay later, in order.
    initial begin
        bus.mem_rd_ack = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge mem_clk); #1;
            if (mem_reset) begin
                bus.mem_rd_ack = 1'b0;
                req_run = 0;
            end else if (bus.mem_rd_ack) begin
                bus.mem_rd_ack = 1'b0;
            end else if (bus.mem_rd_req) begin
                req_run++;
                if (req_run >= ack_delay) begin
                    bus.mem_rd_ack = 1'b1;
                    req_run = 0;
                    ack_cnt++;
                    if (ack_cnt == 1) first_ack_addr = bus.mem_rd_addr;
                    last_ack_addr = bus.mem_rd_addr;
                    if (exp_addrs.size() == 0) check("req_unexpected", 1, 0);
                    else check("req_addr", bus.mem_rd_addr, exp_addrs.pop_front());
                    for (int j = 0; j < 8; j++) begin
                        beat_t bt;
                        bt.ready = cyc + data_delay;
                        bt.data  = mem_word(bus.mem_rd_addr + 29'(j * 16));
                        beat_q.push_back(bt);
                    end
                end
            end
            if (beat_q.size() > 0 && beat_q[0].ready <= cyc) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata = beat_q[0].data;
                void'(beat_q.pop_front());
                if (bus.mem_rd_ack) overlap_cnt++;
            end else begin
                bus.mem_rdata_valid = 1'b0;
            end
        end
    end

    always @(negedge mem_clk) begin
        if (!mem_reset) begin
            if (bus.mem_rd_req) req_cycles++;
            if (bus.pipe_wr_en) begin
                wr_cnt++;
                if (exp_words.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cmp_e = exp_words.pop_front();
                    check("wr_data", bus.pipe_wr_data, cmp_e.data);
                    check("frame_read_on_word", bus.frame_read, cmp_e.fend);
                    check("cam_index", bus.cam_index, cmp_e.cam);
                end
            end else if (bus.frame_read) begin
                check("frame_read_without_data", zb_mode, 1);
            end
            if (bus.frame_read) begin
                fr_cnt++;
                fr_cyc_q.push_back(cyc);
            end
            if (bus.all_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_words_left", exp_words.size(), 0);
                check("done_frames", fr_cnt, 3);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, bus.mem_rd_req, 0);
        check({tag, "_addr"}, bus.mem_rd_addr, 0);
        check({tag, "_wr_en"}, bus.pipe_wr_en, 0);
        check({tag, "_wr_data"}, bus.pipe_wr_data, 0);
        check({tag, "_frame_read"}, bus.frame_read, 0);
        check({tag, "_all_done"}, bus.all_done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_cam_index"}, bus.cam_index, 0);
    endtask

    task automatic run_set(input logic [29:0] sa, input int fb);
        load_model(sa, fb);
        ack_cnt = 0; wr_cnt = 0; fr_cnt = 0; done_cnt = 0; req_cycles = 0; overlap_cnt = 0;
        fr_cyc_q.delete();
        zb_mode = (fb == 0);
        bus.start_addr = sa;
        bus.frame_bursts = 24'(fb);
        bus.start = 1'b1;
        @(posedge mem_clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge mem_clk); #1;
            n++;
        end
        check({name, "_all_done_seen"}, done_cnt, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int snap;
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.frame_bursts = '0;
        bus.pipe_wr_count = '0;
        bus.pipe_full = 1'b0;

        repeat (3) @(posedge mem_clk);
        #1;
        check_reset_vals("rst");
        mem_reset = 1'b0;
        @(posedge mem_clk); #1;

        // Three frames of four bursts from 0x1000.
        ack_delay = 2; data_delay = 10;
        run_set(30'h1000, 4);
        if (HDRW == 0) check("req_next_cycle", bus.mem_rd_req, 1);
        check("busy_after_start", bus.busy, 1);
        wait_done("main", 3000);
        check("main_words", wr_cnt, 96 + 3 * HDRW);
        check("main_frames", fr_cnt, 3);
        check("main_acks", ack_cnt, 12);
        check("main_first_addr", first_ack_addr, 29'h1000);
        check("main_last_addr", last_ack_addr, 29'h1580);
        check("main_done_after_frame", (fr_cyc_q.size() == 3) && (done_cyc > fr_cyc_q[2]), 1);
        repeat (3) @(posedge mem_clk);
        #1;
        check("main_busy_low", bus.busy, 0);
        check("main_single_done", done_cnt, 1);
        check("main_overflow", bus.overflow, 0);

        // FIFO credit: 505 leaves no room for a burst, 504 does.
        bus.pipe_wr_count = 10'd505;
        run_set(30'h4000, 1);
        repeat (20) @(posedge mem_clk);
        #1;
        check("credit_no_req", req_cycles, 0);
        check("credit_busy", bus.busy, 1);
        bus.pipe_wr_count = 10'd504;
        wait_done("credit", 3000);
        check("credit_acks", ack_cnt, 3);
        check("credit_words", wr_cnt, 24 + 3 * HDRW);
        check("credit_overflow", bus.overflow, 0);
        bus.pipe_wr_count = 10'd0;
        repeat (3) @(posedge mem_clk);
        #1;

        // Fast acks interleaved with returning data.
        ack_delay = 1; data_delay = 3;
        run_set(30'h10000, 2);
        wait_done("overlap", 3000);
        check("overlap_words", wr_cnt, 48 + 3 * HDRW);
        check("overlap_acks", ack_cnt, 6);
        check("overlap_seen", overlap_cnt > 0, 1);
        repeat (3) @(posedge mem_clk);
        #1;

        // Zero-length frames.
        ack_delay = 2; data_delay = 10;
        run_set(30'h8000, 0);
        wait_done("zero", 100);
        check("zero_no_req", req_cycles, 0);
        check("zero_frames", fr_cnt, 3);
        check("zero_words", wr_cnt, 0);
        if (fr_cyc_q.size() == 3) begin
            check("zero_fr_gap1", fr_cyc_q[1] - fr_cyc_q[0], 1);
            check("zero_fr_gap2", fr_cyc_q[2] - fr_cyc_q[1], 1);
            check("zero_done_gap", done_cyc - fr_cyc_q[2], 1);
        end
        repeat (3) @(posedge mem_clk);
        #1;

        // Reset after two of four bursts, stale data must be dropped.
        run_set(30'h2000, 4);
        n = 0;
        while (ack_cnt < 2 && n < 500) begin
            @(posedge mem_clk); #1;
            n++;
        end
        check("abort_two_acks", ack_cnt, 2);
        mem_reset = 1'b1;
        #1;
        check_reset_vals("abort");
        repeat (2) @(posedge mem_clk);
        #1;
        mem_reset = 1'b0;
        exp_words.delete();
        exp_addrs.delete();
        snap = wr_cnt;
        n = 0;
        while (beat_q.size() > 0 && n < 500) begin
            @(posedge mem_clk); #1;
            n++;
        end
        repeat (3) @(posedge mem_clk);
        #1;
        check("abort_stale_dropped", wr_cnt - snap, 0);
        check("abort_idle_req", bus.mem_rd_req, 0);
        run_set(30'h3000, 1);
        wait_done("restart", 3000);
        check("restart_first_addr", first_ack_addr, 29'h3000);
        check("restart_words", wr_cnt, 24 + 3 * HDRW);
        repeat (3) @(posedge mem_clk);
        #1;

        // Writing into a full FIFO sets the sticky overflow flag.
        bus.pipe_full = 1'b1;
        run_set(30'h5000, 1);
        wait_done("ovf", 3000);
        bus.pipe_full = 1'b0;
        repeat (3) @(posedge mem_clk);
        #1;
        check("ovf_sticky", bus.overflow, 1);
        mem_reset = 1'b1;
        @(posedge mem_clk); #1;
        check("ovf_cleared_by_reset", bus.overflow, 0);
        mem_reset = 1'b0;
        repeat (2) @(posedge mem_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_mem_reader.md
# image_mem_reader

Reads the captured frames of up to three cameras back out of DDR and streams them into the host-side pipe FIFO. Frames are stored back to back, starting at one base address, by the image interface write chain. The block sits between the memory arbiter's MIG read port and the pipe-out FIFO in the `mem_clk` domain. It issues burst read requests that are throttled by downstream FIFO credit, forwards the returned 128-bit words in order, and reports the end of each camera frame and of the whole set.

## Interface
- `NUM_CAMERAS`, 3: number of frames read per trigger (1–3).
- `BURST_WORDS`, 8: 128-bit words returned per accepted request; the address advances by BURST_WORDS*16 bytes per request.
- `FIFO_DEPTH`, 512: capacity of the downstream pipe FIFO, in words.

Ports:
- `mem_clk` in 1: sole clock.
- `mem_reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a read set.
- `start_addr` in 30: byte address of the camera-1 frame; must be burst-aligned.
- `frame_bursts` in 24: bursts per camera frame; sampled on `start`.
- `mem_rd_req` out 1: read request.
- `mem_rd_addr` out 29: request address, bits [28:0] of the current byte address.
- `mem_rd_ack` in 1: arbiter accepted the request.
- `mem_rdata_valid` in 1: one returned word this cycle.
- `mem_rdata` in 128: returned data.
- `pipe_wr_count` in 10: current fill of the downstream FIFO.
- `pipe_full` in 1: downstream FIFO full.
- `pipe_wr_en` out 1: write strobe to the FIFO.
- `pipe_wr_data` out 128: FIFO write data.
- `frame_read` out 1: pulses when the last word of a camera frame is written.
- `cam_index` out 2: index of the camera whose data is currently being written.
- `all_done` out 1: pulses when the last frame completes.
- `busy` out 1: high from `start` until `all_done`.
- `overflow` out 1: sticky; set if `pipe_wr_en` is asserted while `pipe_full` is high.

## Operation
- States: IDLE, REQ, WAIT_SPACE, DRAIN; HDR exists only when the header option is compiled in.
- IDLE:
  - On `start`, latch `start_addr` and `frame_bursts`.
  - Clear the request camera counter and the receive camera counter.
  - Go to REQ (or HDR when the header option is enabled).
  - `start` is ignored outside IDLE.
- REQ:
  - Assert `mem_rd_req` with `mem_rd_addr` held stable until `mem_rd_ack`.
  - On ack: add BURST_WORDS to the outstanding counter, increment the address, decrement the remaining bursts.
  - When the last burst of the last camera is acked, go to DRAIN.
  - Otherwise go to WAIT_SPACE.
- WAIT_SPACE: return to REQ when `pipe_wr_count + outstanding + BURST_WORDS <= FIFO_DEPTH`.
- Camera advance: when a camera's remaining bursts reach zero, the request camera increments. The address continues contiguously into the next frame.
- Data path:
  - Every `mem_rdata_valid` is registered into `pipe_wr_data`/`pipe_wr_en` and decrements the outstanding counter.
  - Data is in order, so a received-word counter compares against `frame_bursts*BURST_WORDS` to detect the end of a frame.
  - At the end of a frame, `frame_read` is asserted on the same cycle as the final `pipe_wr_en` and the receive camera (`cam_index`) increments.
- DRAIN: wait until the outstanding count is 0 and the final word has been written. Then pulse `all_done` and return to IDLE.
- `frame_bursts` = 0: no requests are issued. Each camera emits `frame_read` on consecutive cycles, followed by `all_done`.
- `start_addr` arithmetic is modulo 2^30.

## Timing
- Reset values:
  - `mem_rd_req`, `pipe_wr_en`, `frame_read`, `all_done`, `busy`, `overflow` = 0.
  - `mem_rd_addr`, `pipe_wr_data` = 0.
  - `cam_index` = 0.
  - State = IDLE.
- `start` → `mem_rd_req` high on the next cycle.
- After `mem_rd_ack`, `mem_rd_req` is low for at least one cycle.
- `mem_rdata_valid` → `pipe_wr_en` has 1 cycle of latency.
- An ack and a data beat in the same cycle are both applied to the outstanding counter (net +BURST_WORDS−1).
- `mem_reset` mid-set aborts immediately. Outstanding data returning after reset is dropped.

## Configuration
- `IMGRD_FRAME_HEADER_EN` defined:
  - Before each camera's first request, HDR waits for outstanding = 0 and one free FIFO slot.
  - It then writes one header word: {32'hFACE_0000 | cam, 8'h0, frame_bursts, 64'h0}.
  - `frame_read` does not count the header.
- Undefined: no header is written, and requests for the next camera may overlap data still returning for the previous camera.

## Structure
- Shared package `image_mem_pkg`:
  - State enum.
  - Header magic 32'hFACE_0000.
  - Bytes-per-word constant (16).
- No sub-module. The credit counter and the received-word counter are inline.

## Test plan
- NUM_CAMERAS=3, `frame_bursts`=4, `start_addr`=0x1000, arbiter acks after 2 cycles, data returns after 10 cycles → addresses 0x1000..0x1580 in steps of 0x80. Expect 96 words in order, 3 `frame_read` pulses, then 1 `all_done`.
- `pipe_wr_count` forced to 505 → no request is issued until the count drops to 504 or below; `overflow` stays 0.
- Ack and `mem_rdata_valid` asserted on the same cycle → the outstanding count is correct and the last word ends the set.
- `frame_bursts`=0 → no `mem_rd_req`; 3 `frame_read` pulses, then `all_done`.
- `mem_reset` asserted after 2 of 4 bursts → all outputs return to reset values; a new `start` restarts at the new `start_addr`.
- With `IMGRD_FRAME_HEADER_EN`, `frame_bursts`=1 → the word sequence is hdr0, 8 data words, hdr1, ….
